l1_mem_arbiter: RTL and testbench

- Shares the single main-memory port between the L1 D-cache (port 0) and the L1 I-cache (port 1).
- Accepts one transaction at a time.
  - Reads are line fills of WORDS_PER_LINE beats.
  - Writes are single-word stores.
- Sequences the memory handshake and routes each response back to the requester that owns the transaction.
- Round-robin arbitration, plus a watchdog so a stalled memory cannot hang either cache.

---
 rtl/l1_mem_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/l1_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_pkg.sv
// Shared types and helpers for the L1 main-memory arbiter.
// Transaction states, requester port ids and fill-address alignment.
package l1_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    FILL,
    WACK
  } state_t;

  localparam logic PORT_DCACHE = 1'b0;
  localparam logic PORT_ICACHE = 1'b1;

  // Clear the byte-offset bits so a fill always starts at the line base.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_bits);
    logic [31:0] mask;
    mask = (32'd1 << offset_bits) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: on contention the port that did not
// own the previous transaction wins; the history advances on i_update.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_update,
  input  logic       i_update_port,
  output logic [1:0] o_grant,
  output logic       o_grant_port
);

  logic r_last_grant;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= i_update_port;
    end
  end

  // NOTE: outputs get defaults first so no path can infer a latch.
  always_comb begin
    o_grant_port = i_req[1];
    o_grant      = 2'b00;
    if (i_req == 2'b11) begin
      o_grant_port = ~r_last_grant;
    end
    if (i_en && (i_req != 2'b00)) begin
      o_grant[o_grant_port] = 1'b1;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one main-memory port between the L1 D-cache (port 0) and I-cache
// (port 1): line fills, single-word stores, per-owner responses, watchdog.
module l1_mem_arbiter
  import l1_mem_pkg::*;
#(
  parameter int  WORDS_PER_LINE = 8,
  parameter int  OFFSET_BITS    = 5,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int BEAT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_write,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic [1:0]        rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [BEAT_W-1:0] rsp_beat,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_wack
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [WD_W-1:0]   r_wd_cnt;

  logic [1:0]        r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [BEAT_W-1:0] r_rsp_beat;
  logic              r_rsp_last;
  logic              r_rsp_err;

  logic [1:0]        w_grant;
  logic              w_grant_port;
  logic [1:0]        w_owner_oh;
  logic              w_drain;
  logic              w_cmd_acc;
  logic              w_fill_beat;
  logic              w_last_beat;
  logic              w_wack;
  logic              w_event;
  logic              w_timeout;

  rr_arbiter2 u_rr (
    .CLK          (CLK),
    .RST          (RST),
    .i_req        (req_valid),
    .i_en         ((r_state == IDLE) && !RST),
    .i_update     (w_drain),
    .i_update_port(r_owner),
    .o_grant      (w_grant),
    .o_grant_port (w_grant_port)
  );

  // The final response is registered, so the transaction stays in its busy
  // state for the cycle that response is visible and then drops to IDLE.
  // Memory events arriving in that cycle belong to no transaction.
  assign w_drain     = r_rsp_last;
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
  assign w_cmd_acc   = (r_state == CMD)  && mem_ready  && !w_drain;
  assign w_fill_beat = (r_state == FILL) && mem_rvalid && !w_drain;
  assign w_wack      = (r_state == WACK) && mem_wack   && !w_drain;
  assign w_last_beat = w_fill_beat && (r_beat_cnt == BEAT_W'(WORDS_PER_LINE - 1));
  assign w_event     = w_cmd_acc || w_fill_beat || w_wack;
  assign w_timeout   = (r_state != IDLE) && !w_drain && !w_event &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant != 2'b00) w_state_nxt = CMD;
      CMD:     if (w_cmd_acc) w_state_nxt = r_write ? WACK : FILL;
      default: ;
    endcase
    if (w_drain) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_owner    <= PORT_DCACHE;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_beat_cnt <= '0;
      r_wd_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant != 2'b00) begin
        r_owner <= w_grant_port;
        r_addr  <= req_addr[{w_grant_port, 5'd0} +: 32];
        r_wdata <= req_wdata[{w_grant_port, 5'd0} +: 32];
        r_write <= req_write[w_grant_port] && (w_grant_port == PORT_DCACHE);
      end

      if (w_drain) begin
        r_beat_cnt <= '0;
      end else if (w_fill_beat && !w_last_beat) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end

      if ((w_state_nxt != r_state) || w_event) begin
        r_wd_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
    end
  end

  // Response path: one registered pulse per beat, store ack or abort.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_beat  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_beat  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (w_fill_beat) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_data  <= mem_rdata;
        r_rsp_beat  <= r_beat_cnt;
        r_rsp_last  <= w_last_beat;
      end else if (w_wack) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_last  <= 1'b1;
      end else if (w_timeout) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_beat  <= r_beat_cnt;
        r_rsp_last  <= 1'b1;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign mem_valid = (r_state == CMD) && !w_drain;
  assign mem_write = mem_valid && r_write;
  assign mem_addr  = mem_valid ? (r_write ? r_addr : line_align(r_addr, OFFSET_BITS)) : '0;
  assign mem_wdata = mem_valid ? r_wdata : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_beat  = r_rsp_beat;
  assign rsp_last  = r_rsp_last;
  assign rsp_err   = r_rsp_err;

  a_rsp_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(rsp_valid));
  a_ready_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(req_ready));
  a_no_rsp_in_idle: assert property (@(posedge CLK) disable iff (RST)
    (r_state == IDLE) |-> (rsp_valid == 2'b00));

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: a scripted memory model pushes the
// expected responses, a negedge monitor pops and compares them.
module tb_l1_mem_arbiter;

  localparam int WPL     = 8;
  localparam int TIMEOUT = 4;

  logic        CLK;
  logic        RST;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_beat;
  logic        rsp_last;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wack;

  l1_mem_arbiter #(
    .WORDS_PER_LINE(WPL),
    .OFFSET_BITS   (5),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_beat  (rsp_beat),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_wack  (mem_wack)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] data;
    logic [2:0]  beat;
    logic        last;
    logic        err;
    bit          chk_data;
    bit          chk_beat;
  } exp_t;

  exp_t sb[$];
  int   n_checks     = 0;
  int   n_errors     = 0;
  int   cyc          = 0;
  int   prev_rsp_cyc = 0;
  int   err_gap      = -1;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] d, input logic [2:0] b,
                      input logic l, input logic er, input bit cd, input bit cb);
    exp_t e;
    e.valid = v; e.data = d; e.beat = b; e.last = l; e.err = er;
    e.chk_data = cd; e.chk_beat = cb;
    sb.push_back(e);
  endtask

  // Response monitor and interface invariants.
  always @(negedge CLK) begin
    exp_t e;
    check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.valid));
        if (e.chk_data) check("rsp_data", 64'(rsp_data), 64'(e.data));
        if (e.chk_beat) check("rsp_beat", 64'(rsp_beat), 64'(e.beat));
        check("rsp_last", 64'(rsp_last), 64'(e.last));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (rsp_err) err_gap = cyc - prev_rsp_cyc;
      end
      prev_rsp_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input logic [1:0] exp, input string tag);
    int n = 0;
    logic [1:0] g;
    @(negedge CLK);
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    g = req_ready;
    check(tag, 64'(req_ready), 64'(exp));
    tick();
    req_valid = req_valid & ~g;
  endtask

  task automatic serve_cmd(input logic [31:0] exp_addr, input logic exp_write,
                           input logic [31:0] exp_wdata, input int delay);
    int n = 0;
    @(negedge CLK);
    while (!mem_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("mem_valid", 64'(mem_valid), 64'd1);
    check("mem_addr", 64'(mem_addr), 64'(exp_addr));
    check("mem_write", 64'(mem_write), 64'(exp_write));
    if (exp_write) check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    repeat (delay) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    @(negedge CLK);
    check("mem_valid_drop", 64'(mem_valid), 64'd0);
  endtask

  task automatic serve_fill(input logic [1:0] owner, input logic [31:0] base, input int nbeats);
    tick();
    for (int i = 0; i < nbeats; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      push(owner, base + 32'(i), 3'(i), (i == WPL - 1), 1'b0, 1'b1, 1'b1);
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic serve_wack(input logic [1:0] owner);
    tick();
    mem_wack = 1'b1;
    push(owner, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    mem_wack = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    RST        = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_wack   = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    @(negedge CLK);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rsp_last_err", 64'({rsp_last, rsp_err}), 64'd0);
    tick();

    // Contention straight out of reset: D first, then I, then D again.
    req_addr  = {32'h0000_2008, 32'h0000_0100};
    req_valid = 2'b11;
    wait_ready(2'b01, "grant_first_d");
    serve_cmd(32'h0000_0100, 1'b0, 32'd0, 1);
    serve_fill(2'b01, 32'h10, WPL);
    drain();
    wait_ready(2'b10, "grant_then_i");
    serve_cmd(32'h0000_2000, 1'b0, 32'd0, 1);
    serve_fill(2'b10, 32'h20, WPL);
    drain();
    req_valid = 2'b11;
    wait_ready(2'b01, "grant_rr_d");
    req_valid = 2'b00;
    serve_cmd(32'h0000_0100, 1'b0, 32'd0, 1);
    serve_fill(2'b01, 32'h30, WPL);
    drain();

    // D-cache line fill with a slow command accept.
    req_addr  = {32'h0, 32'h0000_1234};
    req_valid = 2'b01;
    wait_ready(2'b01, "grant_d_read");
    serve_cmd(32'h0000_1220, 1'b0, 32'd0, 2);
    serve_fill(2'b01, 32'hA0, WPL);
    drain();

    // D-cache store.
    req_addr  = {32'h0, 32'h0000_0040};
    req_wdata = {32'h0, 32'hDEAD_BEEF};
    req_write = 2'b01;
    req_valid = 2'b01;
    wait_ready(2'b01, "grant_d_store");
    req_write = 2'b00;
    serve_cmd(32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 1);
    serve_wack(2'b01);
    drain();

    // I-cache store attempt is treated as a line fill.
    req_addr  = {32'h0000_3004, 32'h0};
    req_wdata = {32'h1234_5678, 32'h0};
    req_write = 2'b10;
    req_valid = 2'b10;
    wait_ready(2'b10, "grant_i_store");
    req_write = 2'b00;
    serve_cmd(32'h0000_3000, 1'b0, 32'd0, 1);
    serve_fill(2'b10, 32'hB0, WPL);
    drain();

    // Fill stalls after three beats: watchdog abort, then a new grant.
    req_addr  = {32'h0, 32'h0000_0500};
    req_valid = 2'b01;
    wait_ready(2'b01, "grant_d_timeout");
    serve_cmd(32'h0000_0500, 1'b0, 32'd0, 1);
    serve_fill(2'b01, 32'hC0, 3);
    push(2'b01, 32'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("timeout_gap", 64'(err_gap), 64'd4);
    req_addr  = {32'h0000_6010, 32'h0};
    req_valid = 2'b10;
    wait_ready(2'b10, "grant_after_timeout");
    serve_cmd(32'h0000_6000, 1'b0, 32'd0, 1);
    serve_fill(2'b10, 32'hD0, WPL);
    drain();

    // Reset during beat 4 of a D fill.
    req_addr  = {32'h0, 32'h0000_0700};
    req_valid = 2'b01;
    wait_ready(2'b01, "grant_d_reset");
    serve_cmd(32'h0000_0700, 1'b0, 32'd0, 1);
    serve_fill(2'b01, 32'hE0, 4);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hE4;
    RST        = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("rrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rrst_rsp_data", 64'(rsp_data), 64'd0);
    check("rrst_rsp_last_err", 64'({rsp_last, rsp_err}), 64'd0);
    check("rrst_mem_valid", 64'(mem_valid), 64'd0);
    check("rrst_mem_addr", 64'(mem_addr), 64'd0);
    check("rrst_req_ready", 64'(req_ready), 64'd0);
    repeat (3) tick();
    mem_rvalid = 1'b0;
    check("rrst_sb_empty", 64'(sb.size()), 64'd0);
    req_addr  = {32'h0000_7000, 32'h0000_0800};
    req_valid = 2'b11;
    wait_ready(2'b01, "grant_post_reset_d");
    serve_cmd(32'h0000_0800, 1'b0, 32'd0, 1);
    serve_fill(2'b01, 32'hF0, WPL);
    drain();
    wait_ready(2'b10, "grant_post_reset_i");
    serve_cmd(32'h0000_7000, 1'b0, 32'd0, 1);
    serve_fill(2'b10, 32'h70, WPL);
    drain();

    repeat (2) tick();
    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
